// File: rtl/ev_latency_stats.sv
// rtl/ev_latency_stats.sv - per-ID latency statistics accumulator with snapshot/clear read port
//
// Purpose: consumes (id, delta) samples from the event timer and keeps
//   count / min / max / saturating sum / sticky sat per ID. A request/response
//   port returns a snapshot of one ID, optionally clearing it atomically.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            sample handshake; in_id, in_delta sample payload
//   rd_req_valid/rd_req_ready    read request handshake; rd_id, rd_clear request payload
//   rd_resp_valid/rd_resp_ready  response handshake
//   rd_resp_id/count/min/max/sum/sat  snapshot of the requested entry

module ev_latency_stats #(
  parameter int ID_W  = 3,
  parameter int TS_W  = 8,
  parameter int CNT_W = 16,
  parameter int SUM_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ID_W-1:0]  in_id,
  input  logic [TS_W-1:0]  in_delta,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [ID_W-1:0]  rd_id,
  input  logic             rd_clear,
  output logic             rd_resp_valid,
  input  logic             rd_resp_ready,
  output logic [ID_W-1:0]  rd_resp_id,
  output logic [CNT_W-1:0] rd_resp_count,
  output logic [TS_W-1:0]  rd_resp_min,
  output logic [TS_W-1:0]  rd_resp_max,
  output logic [SUM_W-1:0] rd_resp_sum,
  output logic             rd_resp_sat
);

  localparam int DEPTH = 1 << ID_W;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] count_q [DEPTH];
  logic [TS_W-1:0]  min_q   [DEPTH];
  logic [TS_W-1:0]  max_q   [DEPTH];
  logic [SUM_W-1:0] sum_q   [DEPTH];
  logic             sat_q   [DEPTH];

  logic rd_take;
  logic in_take;
  logic collision;

  logic [CNT_W:0]   cnt_ext;
  logic [SUM_W:0]   sum_ext;
  logic [CNT_W-1:0] upd_count;
  logic [SUM_W-1:0] upd_sum;
  logic [TS_W-1:0]  upd_min;
  logic [TS_W-1:0]  upd_max;
  logic             upd_sat;

  // Handshakes. A clearing read of the same ID as the incoming sample stalls
  // the sample for one cycle so it lands in the cleared entry, never in the
  // discarded snapshot.
  assign rd_req_ready = !rst && ((state_q == S_EMPTY) || rd_resp_ready);
  assign rd_take      = rd_req_valid && rd_req_ready;
  assign collision    = rd_take && rd_clear && (rd_id == in_id);
  assign in_ready     = !rst && !collision;
  assign in_take      = in_valid && in_ready;

  // Sample update, computed one bit wider than the field and then clamped.
  always_comb begin
    cnt_ext   = {1'b0, count_q[in_id]} + {{CNT_W{1'b0}}, 1'b1};
    sum_ext   = {1'b0, sum_q[in_id]} + {{(SUM_W + 1 - TS_W){1'b0}}, in_delta};
    upd_count = cnt_ext[CNT_W] ? {CNT_W{1'b1}} : cnt_ext[CNT_W-1:0];
    upd_sum   = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    upd_min   = (in_delta < min_q[in_id]) ? in_delta : min_q[in_id];
    upd_max   = (in_delta > max_q[in_id]) ? in_delta : max_q[in_id];
    upd_sat   = sat_q[in_id] | cnt_ext[CNT_W] | sum_ext[SUM_W];
  end

  // Entry storage. The clear and the sample update never address the same
  // entry in one cycle (collision stall), so their writes are independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        count_q[i] <= '0;
        min_q[i]   <= '1;
        max_q[i]   <= '0;
        sum_q[i]   <= '0;
        sat_q[i]   <= 1'b0;
      end
    end else begin
      if (rd_take && rd_clear) begin
        count_q[rd_id] <= '0;
        min_q[rd_id]   <= '1;
        max_q[rd_id]   <= '0;
        sum_q[rd_id]   <= '0;
        sat_q[rd_id]   <= 1'b0;
      end
      if (in_take) begin
        count_q[in_id] <= upd_count;
        min_q[in_id]   <= upd_min;
        max_q[in_id]   <= upd_max;
        sum_q[in_id]   <= upd_sum;
        sat_q[in_id]   <= upd_sat;
      end
    end
  end

  // Response register FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (rd_take) state_d = S_FULL;
      S_FULL:  if (rd_resp_ready && !rd_take) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  assign rd_resp_valid = (state_q == S_FULL);

  // Snapshot is taken from pre-edge entry state, so a same-cycle sample is excluded.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_resp_id    <= '0;
      rd_resp_count <= '0;
      rd_resp_min   <= '0;
      rd_resp_max   <= '0;
      rd_resp_sum   <= '0;
      rd_resp_sat   <= 1'b0;
    end else if (rd_take) begin
      rd_resp_id    <= rd_id;
      rd_resp_count <= count_q[rd_id];
      rd_resp_min   <= min_q[rd_id];
      rd_resp_max   <= max_q[rd_id];
      rd_resp_sum   <= sum_q[rd_id];
      rd_resp_sat   <= sat_q[rd_id];
    end
  end

endmodule

// File: tb/tb_ev_latency_stats.sv
// tb/tb_ev_latency_stats.sv - directed self-checking bench for ev_latency_stats

module tb_ev_latency_stats;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_id;
  logic [7:0] in_delta;
  logic       rd_req_valid;
  logic [2:0] rd_id;
  logic       rd_clear;
  logic       rd_resp_ready;

  logic        in_ready, rd_req_ready, rd_resp_valid, rd_resp_sat;
  logic [2:0]  rd_resp_id;
  logic [15:0] rd_resp_count;
  logic [7:0]  rd_resp_min, rd_resp_max;
  logic [23:0] rd_resp_sum;

  logic        in_ready_a, rd_req_ready_a, rd_resp_valid_a, rd_resp_sat_a;
  logic [2:0]  rd_resp_id_a;
  logic [3:0]  rd_resp_count_a;
  logic [7:0]  rd_resp_min_a, rd_resp_max_a;
  logic [23:0] rd_resp_sum_a;

  logic        in_ready_b, rd_req_ready_b, rd_resp_valid_b, rd_resp_sat_b;
  logic [2:0]  rd_resp_id_b;
  logic [3:0]  rd_resp_count_b;
  logic [7:0]  rd_resp_min_b, rd_resp_max_b;
  logic [9:0]  rd_resp_sum_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ev_latency_stats dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_delta(in_delta),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_id(rd_id), .rd_clear(rd_clear),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_id(rd_resp_id),
    .rd_resp_count(rd_resp_count), .rd_resp_min(rd_resp_min), .rd_resp_max(rd_resp_max),
    .rd_resp_sum(rd_resp_sum), .rd_resp_sat(rd_resp_sat)
  );

  ev_latency_stats #(.CNT_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_id(in_id), .in_delta(in_delta),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready_a), .rd_id(rd_id), .rd_clear(rd_clear),
    .rd_resp_valid(rd_resp_valid_a), .rd_resp_ready(rd_resp_ready), .rd_resp_id(rd_resp_id_a),
    .rd_resp_count(rd_resp_count_a), .rd_resp_min(rd_resp_min_a), .rd_resp_max(rd_resp_max_a),
    .rd_resp_sum(rd_resp_sum_a), .rd_resp_sat(rd_resp_sat_a)
  );

  ev_latency_stats #(.CNT_W(4), .SUM_W(10)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_id(in_id), .in_delta(in_delta),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready_b), .rd_id(rd_id), .rd_clear(rd_clear),
    .rd_resp_valid(rd_resp_valid_b), .rd_resp_ready(rd_resp_ready), .rd_resp_id(rd_resp_id_b),
    .rd_resp_count(rd_resp_count_b), .rd_resp_min(rd_resp_min_b), .rd_resp_max(rd_resp_max_b),
    .rd_resp_sum(rd_resp_sum_b), .rd_resp_sat(rd_resp_sat_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a read request for one edge, then withdraw it.
  task automatic do_read(input logic [2:0] id, input logic clr);
    rd_req_valid = 1'b1;
    rd_id        = id;
    rd_clear     = clr;
    tick();
    rd_req_valid = 1'b0;
    rd_clear     = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [15:0] cnt, input logic [7:0] mn,
                            input logic [7:0] mx, input logic [23:0] sm, input logic st);
    check({tag, ".valid"}, 32'(rd_resp_valid), 32'd1);
    check({tag, ".count"}, 32'(rd_resp_count), 32'(cnt));
    check({tag, ".min"},   32'(rd_resp_min),   32'(mn));
    check({tag, ".max"},   32'(rd_resp_max),   32'(mx));
    check({tag, ".sum"},   32'(rd_resp_sum),   32'(sm));
    check({tag, ".sat"},   32'(rd_resp_sat),   32'(st));
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_id         = '0;
    in_delta      = '0;
    rd_req_valid  = 1'b0;
    rd_id         = '0;
    rd_clear      = 1'b0;
    rd_resp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst.in_ready",      32'(in_ready),      32'd0);
    check("rst.rd_req_ready",  32'(rd_req_ready),  32'd0);
    check("rst.rd_resp_valid", 32'(rd_resp_valid), 32'd0);
    check("rst.count",         32'(rd_resp_count), 32'd0);
    check("rst.min",           32'(rd_resp_min),   32'd0);
    rst = 1'b0;
    #1;
    check("post_rst.in_ready",     32'(in_ready),     32'd1);
    check("post_rst.rd_req_ready", 32'(rd_req_ready), 32'd1);

    // Basic accumulation: id 2 gets 5, 9, 3
    in_valid = 1'b1;
    in_id    = 3'd2;
    in_delta = 8'd5; tick();
    in_delta = 8'd9; tick();
    in_delta = 8'd3; tick();
    in_valid = 1'b0;
    check("basic.valid_before", 32'(rd_resp_valid), 32'd0);
    do_read(3'd2, 1'b0);
    check("basic.id", 32'(rd_resp_id), 32'd2);
    check_resp("basic", 16'd3, 8'd3, 8'd9, 24'd17, 1'b0);

    // Empty entry and read-with-clear
    do_read(3'd6, 1'b0);
    check_resp("empty6", 16'd0, 8'd255, 8'd0, 24'd0, 1'b0);
    do_read(3'd2, 1'b1);
    check_resp("clear2", 16'd3, 8'd3, 8'd9, 24'd17, 1'b0);
    do_read(3'd2, 1'b0);
    check_resp("after_clear2", 16'd0, 8'd255, 8'd0, 24'd0, 1'b0);

    // Same-cycle sample and non-clearing read of id 1
    in_valid     = 1'b1;
    in_id        = 3'd1;
    in_delta     = 8'd7;
    rd_req_valid = 1'b1;
    rd_id        = 3'd1;
    rd_clear     = 1'b0;
    #1;
    check("same.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid     = 1'b0;
    rd_req_valid = 1'b0;
    check_resp("same.snap", 16'd0, 8'd255, 8'd0, 24'd0, 1'b0);
    do_read(3'd1, 1'b0);
    check_resp("same.after", 16'd1, 8'd7, 8'd7, 24'd7, 1'b0);

    // Collision: clear-read of id 4 with a sample to id 4 in the same cycle
    in_valid = 1'b1;
    in_id    = 3'd4;
    in_delta = 8'd20;
    tick();
    in_delta     = 8'd10;
    rd_req_valid = 1'b1;
    rd_id        = 3'd4;
    rd_clear     = 1'b1;
    #1;
    check("coll.in_ready_low", 32'(in_ready), 32'd0);
    tick();
    rd_req_valid = 1'b0;
    rd_clear     = 1'b0;
    check_resp("coll.snap", 16'd1, 8'd20, 8'd20, 24'd20, 1'b0);
    #1;
    check("coll.in_ready_high", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    do_read(3'd4, 1'b0);
    check_resp("coll.after", 16'd1, 8'd10, 8'd10, 24'd10, 1'b0);
    tick();

    // Response backpressure, then back-to-back reload
    rd_resp_ready = 1'b0;
    do_read(3'd1, 1'b0);
    rd_req_valid = 1'b1;
    rd_id        = 3'd3;
    for (int i = 0; i < 5; i++) begin
      check("bp.rd_req_ready", 32'(rd_req_ready), 32'd0);
      check("bp.id",           32'(rd_resp_id),   32'd1);
      check_resp("bp", 16'd1, 8'd7, 8'd7, 24'd7, 1'b0);
      tick();
    end
    rd_resp_ready = 1'b1;
    rd_id         = 3'd4;
    #1;
    check("bp.release_ready", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    check("bp.reload_id", 32'(rd_resp_id), 32'd4);
    check_resp("bp.reload", 16'd1, 8'd10, 8'd10, 24'd10, 1'b0);
    tick();
    check("bp.drained", 32'(rd_resp_valid), 32'd0);

    // Saturation: 17 samples of 255 to id 0
    in_valid = 1'b1;
    in_id    = 3'd0;
    in_delta = 8'd255;
    for (int i = 0; i < 17; i++) begin
      #1;
      check("sat.in_ready_a", 32'(in_ready_a), 32'd1);
      check("sat.in_ready_b", 32'(in_ready_b), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check("sat.rd_req_ready_a", 32'(rd_req_ready_a), 32'd1);
    check("sat.rd_req_ready_b", 32'(rd_req_ready_b), 32'd1);
    do_read(3'd0, 1'b0);
    check_resp("sat.wide", 16'd17, 8'd255, 8'd255, 24'd4335, 1'b0);
    check("sat_a.valid", 32'(rd_resp_valid_a), 32'd1);
    check("sat_a.id",    32'(rd_resp_id_a),    32'd0);
    check("sat_a.count", 32'(rd_resp_count_a), 32'd15);
    check("sat_a.min",   32'(rd_resp_min_a),   32'd255);
    check("sat_a.max",   32'(rd_resp_max_a),   32'd255);
    check("sat_a.sum",   32'(rd_resp_sum_a),   32'd4335);
    check("sat_a.sat",   32'(rd_resp_sat_a),   32'd1);
    check("sat_b.valid", 32'(rd_resp_valid_b), 32'd1);
    check("sat_b.id",    32'(rd_resp_id_b),    32'd0);
    check("sat_b.count", 32'(rd_resp_count_b), 32'd15);
    check("sat_b.min",   32'(rd_resp_min_b),   32'd255);
    check("sat_b.max",   32'(rd_resp_max_b),   32'd255);
    check("sat_b.sum",   32'(rd_resp_sum_b),   32'd1023);
    check("sat_b.sat",   32'(rd_resp_sat_b),   32'd1);

    // Reset mid-operation discards pending response and statistics
    rd_resp_ready = 1'b0;
    do_read(3'd1, 1'b0);
    check("midrst.pending", 32'(rd_resp_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst.valid", 32'(rd_resp_valid), 32'd0);
    check("midrst.count", 32'(rd_resp_count), 32'd0);
    rst           = 1'b0;
    rd_resp_ready = 1'b1;
    do_read(3'd0, 1'b0);
    check_resp("midrst.id0", 16'd0, 8'd255, 8'd0, 24'd0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
